// File: rtl/n_digit_segment_display_pkg.sv
// Shared types and segment encodings for the N-digit seven-segment driver.
// Patterns are active-low, bit order gfedcba.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_UPDATE = 2'd2
  } disp_state_e;

  localparam seg7_t SEG_BLANK = 7'b1111111;
  localparam seg7_t SEG_MINUS = 7'b0111111;

  localparam seg7_t SEG_DIGIT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  // Non-decimal nibbles map to blank rather than a hex glyph.
  function automatic seg7_t bcd_to_seg7(input logic [3:0] nib);
    seg7_t seg;
    case (nib)
      4'd0:    seg = SEG_DIGIT[0];
      4'd1:    seg = SEG_DIGIT[1];
      4'd2:    seg = SEG_DIGIT[2];
      4'd3:    seg = SEG_DIGIT[3];
      4'd4:    seg = SEG_DIGIT[4];
      4'd5:    seg = SEG_DIGIT[5];
      4'd6:    seg = SEG_DIGIT[6];
      4'd7:    seg = SEG_DIGIT[7];
      4'd8:    seg = SEG_DIGIT[8];
      4'd9:    seg = SEG_DIGIT[9];
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/n_digit_segment_display_if.sv
// Value handshake between a producer and the display driver.
interface n_digit_segment_display_if #(
  parameter int VALUE_WIDTH = 16
) ();

  logic                   load;
  logic [VALUE_WIDTH-1:0] value;
  logic                   ready;

  modport master (output load, output value, input ready);
  modport slave  (input load, input value, output ready);

endinterface

// File: rtl/n_digit_segment_display_b2b.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle,
// with a sticky carry that flags magnitudes too large for the BCD register.
module bin_to_bcd_seq #(
  parameter int VALUE_WIDTH = 16,
  parameter int NUM_DIGITS  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [VALUE_WIDTH-1:0]  bin,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_DIGITS*4-1:0] bcd,
  output logic                    carry
);

  localparam int BW = NUM_DIGITS * 4;
  localparam int CW = $clog2(VALUE_WIDTH + 1);

  logic [CW-1:0]          cnt_q, cnt_d;
  logic [VALUE_WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]          bcd_q, bcd_d;
  logic [BW-1:0]          bcd_adj;
  logic                   carry_q, carry_d;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    carry_d = carry_q;
    if (start) begin
      cnt_d   = CW'(VALUE_WIDTH);
      bin_d   = bin;
      bcd_d   = '0;
      carry_d = 1'b0;
    end else if (cnt_q != '0) begin
      // The bit leaving the top nibble means the value needs another digit.
      {bcd_d, bin_d} = {bcd_adj[BW-2:0], bin_q, 1'b0};
      carry_d        = carry_q | bcd_adj[BW-1];
      cnt_d          = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      carry_q <= carry_d;
    end
  end

  assign busy  = (cnt_q != '0);
  assign done  = (cnt_q == CW'(1));
  assign bcd   = bcd_q;
  assign carry = carry_q;

endmodule

// File: rtl/n_digit_segment_display.sv
// N-digit decimal driver for active-low seven-segment displays: handshake,
// sign handling, leading-zero blanking, minus placement and registered HEX.
module n_digit_segment_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int VALUE_WIDTH   = 16,
  parameter int SIGNED_MODE   = 0,
  parameter int BLANK_LEADING = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  n_digit_segment_display_if.slave bus,
  output seg7_t [NUM_DIGITS-1:0]   HEX,
  output logic                     overflow
);

  localparam int BW = NUM_DIGITS * 4;
  localparam logic [VALUE_WIDTH-1:0] ONE = VALUE_WIDTH'(1);

  disp_state_e            state_q, state_d;
  logic                   sign_q, sign_d;
  seg7_t [NUM_DIGITS-1:0] hex_q, hex_d, hex_new;
  logic                   ovf_q, ovf_d, ovf_new;

  logic                   neg_in;
  logic [VALUE_WIDTH-1:0] mag_in;
  logic                   start;
  logic                   conv_busy;
  logic                   conv_done;
  logic                   conv_carry;
  logic [BW-1:0]          conv_bcd;
  int                     hi;

  // Negation at full width keeps the most negative value as 2^(W-1).
  assign neg_in = (SIGNED_MODE != 0) && bus.value[VALUE_WIDTH-1];
  assign mag_in = neg_in ? (~bus.value + ONE) : bus.value;

  bin_to_bcd_seq #(
    .VALUE_WIDTH (VALUE_WIDTH),
    .NUM_DIGITS  (NUM_DIGITS)
  ) u_b2b (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (mag_in),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd),
    .carry (conv_carry)
  );

  always_comb begin
    hi = 0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (conv_bcd[4*i +: 4] != 4'd0) hi = i;
    end
    // A negative value needs a free top digit to carry the minus glyph.
    ovf_new = conv_carry || (sign_q && (conv_bcd[BW-1 -: 4] != 4'd0));
    for (int i = 0; i < NUM_DIGITS; i++) begin
      hex_new[i] = bcd_to_seg7(conv_bcd[4*i +: 4]);
      if (ovf_new) begin
        hex_new[i] = SEG_MINUS;
      end else if (BLANK_LEADING != 0) begin
        if (i > hi) hex_new[i] = (sign_q && (i == hi + 1)) ? SEG_MINUS : SEG_BLANK;
      end else if (sign_q && (i == NUM_DIGITS - 1)) begin
        hex_new[i] = SEG_MINUS;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    hex_d     = hex_q;
    ovf_d     = ovf_q;
    start     = 1'b0;
    bus.ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.ready = 1'b1;
        if (bus.load) begin
          start   = 1'b1;
          sign_d  = neg_in;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (conv_done || !conv_busy) state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        hex_d   = hex_new;
        ovf_d   = ovf_new;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sign_q  <= 1'b0;
      hex_q   <= {NUM_DIGITS{SEG_BLANK}};
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      hex_q   <= hex_d;
      ovf_q   <= ovf_d;
    end
  end

  assign HEX      = hex_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_n_digit_segment_display.sv
// Scoreboard bench: three driver configurations share one random stimulus
// stream and are checked against an arithmetic reference model.
module tb_n_digit_segment_display;

  localparam int W = 16;
  localparam int N = 4;
  localparam int LAT = W + 2;

  typedef struct packed {
    logic [31:0]      due;
    logic [2:0]       ovf;
    logic [2:0][27:0] hex;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          next_ready = 0;
  exp_t        sb[$];

  bit          sgn_cfg [3] = '{1'b0, 1'b1, 1'b1};
  bit          blk_cfg [3] = '{1'b1, 1'b1, 1'b0};
  logic [6:0]  SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  logic [6:0]  BLANK = 7'b1111111;
  logic [6:0]  MINUS = 7'b0111111;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  n_digit_segment_display_if #(.VALUE_WIDTH(W)) if_0 ();
  n_digit_segment_display_if #(.VALUE_WIDTH(W)) if_1 ();
  n_digit_segment_display_if #(.VALUE_WIDTH(W)) if_2 ();

  assign if_0.load = load;  assign if_0.value = value;
  assign if_1.load = load;  assign if_1.value = value;
  assign if_2.load = load;  assign if_2.value = value;

  logic [3:0][6:0] hex0, hex1, hex2;
  logic            ovf0, ovf1, ovf2;
  logic [27:0]     hx  [3];
  logic            ov  [3];
  logic            rdy [3];

  assign hx[0] = hex0;  assign ov[0] = ovf0;  assign rdy[0] = if_0.ready;
  assign hx[1] = hex1;  assign ov[1] = ovf1;  assign rdy[1] = if_1.ready;
  assign hx[2] = hex2;  assign ov[2] = ovf2;  assign rdy[2] = if_2.ready;

  n_digit_segment_display #(.NUM_DIGITS(N), .VALUE_WIDTH(W), .SIGNED_MODE(0), .BLANK_LEADING(1))
    dut_0 (.clk(clk), .rst(rst), .bus(if_0), .HEX(hex0), .overflow(ovf0));
  n_digit_segment_display #(.NUM_DIGITS(N), .VALUE_WIDTH(W), .SIGNED_MODE(1), .BLANK_LEADING(1))
    dut_1 (.clk(clk), .rst(rst), .bus(if_1), .HEX(hex1), .overflow(ovf1));
  n_digit_segment_display #(.NUM_DIGITS(N), .VALUE_WIDTH(W), .SIGNED_MODE(1), .BLANK_LEADING(0))
    dut_2 (.clk(clk), .rst(rst), .bus(if_2), .HEX(hex2), .overflow(ovf2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Decimal rendering straight from the display rules, using integer arithmetic.
  function automatic logic [28:0] model(input logic [15:0] v, input bit sgn, input bit blk);
    int              mag;
    int              tmp;
    int              ndig;
    int              d [4];
    bit              neg;
    logic            o;
    logic [3:0][6:0] h;
    neg  = sgn && v[15];
    mag  = neg ? (65536 - int'(v)) : int'(v);
    tmp  = mag;
    ndig = 1;
    for (int i = 0; i < N; i++) begin
      d[i] = tmp % 10;
      tmp  = tmp / 10;
      if (d[i] != 0) ndig = i + 1;
    end
    o = (mag >= 10000) || (neg && ndig == N);
    for (int i = 0; i < N; i++) begin
      if (o)                            h[i] = MINUS;
      else if (blk && i >= ndig)        h[i] = (neg && i == ndig) ? MINUS : BLANK;
      else if (!blk && neg && i == N-1) h[i] = MINUS;
      else                              h[i] = SEG[d[i]];
    end
    return {o, h};
  endfunction

  function automatic logic [15:0] rand_val();
    case ($urandom_range(0, 3))
      0:       return 16'($urandom_range(0, 65535));
      1:       return 16'($urandom_range(0, 9999));
      2:       return 16'($urandom_range(0, 99));
      default: return 16'(65536 - $urandom_range(1, 1200));
    endcase
  endfunction

  task automatic drive(input logic ld, input logic [15:0] v, output bit acc);
    bit   er;
    exp_t e;
    @(negedge clk);
    load  = ld;
    value = v;
    er    = (cyc >= next_ready);
    for (int k = 0; k < 3; k++) check($sformatf("ready[%0d]", k), 32'(rdy[k]), 32'(er));
    acc = ld && er;
    if (acc) begin
      e.due = 32'(cyc + LAT);
      for (int k = 0; k < 3; k++) {e.ovf[k], e.hex[k]} = model(v, sgn_cfg[k], blk_cfg[k]);
      sb.push_back(e);
      next_ready = cyc + LAT;
    end
  endtask

  task automatic send(input logic [15:0] v);
    bit acc;
    acc = 1'b0;
    for (int t = 0; t < 2 * LAT && !acc; t++) drive(1'b1, v, acc);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int t = 0; t < n; t++) drive(1'b0, rand_val(), acc);
  endtask

  task automatic check_blank(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_hex[%0d]", tag, k), 32'(hx[k]), 32'({N{BLANK}}));
      check($sformatf("%s_ovf[%0d]", tag, k), 32'(ov[k]), 32'd0);
      check($sformatf("%s_ready[%0d]", tag, k), 32'(rdy[k]), 32'd1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    load = 1'b0;
    repeat (2) @(negedge clk);
    sb.delete();
    next_ready = 0;
    check_blank("reset");
    rst = 1'b0;
  endtask

  // Monitor: every rising ready outside reset is a completed display update.
  initial begin
    bit   prev [3];
    bit   rise;
    exp_t e;
    prev = '{1'b1, 1'b1, 1'b1};
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = '{1'b1, 1'b1, 1'b1};
      end else begin
        rise = 1'b0;
        for (int k = 0; k < 3; k++) if (!prev[k] && rdy[k]) rise = 1'b1;
        if (rise) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_update: update seen at cycle %0d, expected none", cyc);
          end else begin
            e = sb.pop_front();
            check("latency", 32'(cyc), e.due);
            for (int k = 0; k < 3; k++) begin
              check($sformatf("hex[%0d]", k), 32'(hx[k]), 32'(e.hex[k]));
              check($sformatf("ovf[%0d]", k), 32'(ov[k]), 32'(e.ovf[k]));
            end
          end
        end
        for (int k = 0; k < 3; k++) prev[k] = rdy[k];
      end
    end
  end

  initial begin
    logic [15:0] dirv [10];
    bit          acc;
    dirv = '{16'd1234, 16'd7, 16'd0, 16'hFFD6, 16'hFB2E, 16'd10000, 16'd9999,
             16'h8000, 16'hFFFF, 16'd42};

    do_reset();

    foreach (dirv[i]) begin
      send(dirv[i]);
      idle(int'($urandom_range(0, 2)));
    end
    idle(LAT);

    // Abort mid-conversion: nothing from 1234 may surface afterwards.
    send(16'd1234);
    idle(8);
    do_reset();
    idle(25);
    check_blank("post_abort");

    // load held high across the busy window with a changed value.
    send(16'd11);
    send(16'd22);
    idle(LAT);

    for (int n = 0; n < 800; n++) begin
      drive(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0, rand_val(), acc);
    end

    for (int t = 0; t < 4 * LAT && sb.size() != 0; t++) drive(1'b0, 16'd0, acc);
    check("drain", 32'(sb.size()), 32'd0);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
